// File: rtl/g729_pitch_pkg.sv
// rtl/g729_pitch_pkg.sv - shared constants and state encoding for the open-loop pitch scheduler
package g729_pitch_pkg;

    localparam logic signed [15:0] PIT_MAX   = 16'sd143;
    localparam logic signed [15:0] B1_MIN    = 16'sd80;
    localparam logic signed [15:0] B2_MAX    = 16'sd79;
    localparam logic signed [15:0] B2_MIN    = 16'sd40;
    localparam logic signed [15:0] B3_MAX    = 16'sd39;
    localparam logic signed [15:0] PIT_MIN   = 16'sd20;
    localparam logic signed [15:0] THRESHPIT = 16'sd27853;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CMP1  = 3'd3,
        ST_CMP1S = 3'd4,
        ST_CMP2  = 3'd5,
        ST_CMP2S = 3'd6,
        ST_DONE  = 3'd7
    } pitch_state_e;

    // Upper lag of a search band (band 0 is the longest lags)
    function automatic logic [15:0] band_max(input logic [1:0] band);
        case (band)
            2'd0:    band_max = PIT_MAX;
            2'd1:    band_max = B2_MAX;
            default: band_max = B3_MAX;
        endcase
    endfunction

    // Lower lag of a search band
    function automatic logic [15:0] band_min(input logic [1:0] band);
        case (band)
            2'd0:    band_min = B1_MIN;
            2'd1:    band_min = B2_MIN;
            default: band_min = PIT_MIN;
        endcase
    endfunction

endpackage

// File: rtl/pitch_ol_sched.sv
// rtl/pitch_ol_sched.sv - three-band Lag_max sequencer with favour-lower-lag decision
module pitch_ol_sched
    import g729_pitch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] T_op,
    output logic        lm_start,
    output logic [15:0] lm_lag_max,
    output logic [15:0] lm_lag_min,
    input  logic        lm_done,
    input  logic [15:0] lm_cor_max,
    input  logic [15:0] lm_p_max,
    input  logic [15:0] lm_mult_a,
    input  logic [15:0] lm_mult_b,
    input  logic [15:0] lm_sub_a,
    input  logic [15:0] lm_sub_b,
    output logic [15:0] mult_a,
    output logic [15:0] mult_b,
    input  logic [15:0] mult_in,
    output logic [15:0] sub_a,
    output logic [15:0] sub_b,
    input  logic [15:0] sub_in
);

    pitch_state_e      state_q, state_d;
    logic [1:0]        band_q, band_d;
    logic [2:0][15:0]  cor_q, cor_d;
    logic [2:0][15:0]  lag_q, lag_d;
    logic [15:0]       prod_q, prod_d;
    logic [15:0]       max1_q, max1_d;
    logic [15:0]       best_q, best_d;
    logic [15:0]       t_op_q, t_op_d;
    logic              done_q, done_d;

    // State and datapath registers; reset aborts a run with no done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            band_q  <= 2'd0;
            cor_q   <= '0;
            lag_q   <= '0;
            prod_q  <= 16'd0;
            max1_q  <= 16'd0;
            best_q  <= 16'd0;
            t_op_q  <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            band_q  <= band_d;
            cor_q   <= cor_d;
            lag_q   <= lag_d;
            prod_q  <= prod_d;
            max1_q  <= max1_d;
            best_q  <= best_d;
            t_op_q  <= t_op_d;
            done_q  <= done_d;
        end
    end

    // Next-state, band sequencing and the two threshold comparisons
    always_comb begin
        state_d = state_q;
        band_d  = band_q;
        cor_d   = cor_q;
        lag_d   = lag_q;
        prod_d  = prod_q;
        max1_d  = max1_q;
        best_d  = best_q;
        t_op_d  = t_op_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    band_d  = 2'd0;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (lm_done) begin
                    cor_d[band_q] = lm_cor_max;
                    lag_d[band_q] = lm_p_max;
                    if (band_q < 2'd2) begin
                        band_d  = band_q + 2'd1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_CMP1;
                    end
                end
            end
            ST_CMP1: begin
                max1_d  = cor_q[0];
                prod_d  = mult_in;
                state_d = ST_CMP1S;
            end
            ST_CMP1S: begin
                // Strictly negative difference only: a tie keeps the longer lag
                if (sub_in[15]) begin
                    max1_d = cor_q[1];
                    best_d = lag_q[1];
                end else begin
                    best_d = lag_q[0];
                end
                state_d = ST_CMP2;
            end
            ST_CMP2: begin
                prod_d  = mult_in;
                state_d = ST_CMP2S;
            end
            ST_CMP2S: begin
                if (sub_in[15]) best_d = lag_q[2];
                state_d = ST_DONE;
            end
            ST_DONE: begin
                t_op_d  = best_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and shared-unit operand mux: Lag_max owns the units while it runs
    always_comb begin
        busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
        lm_start   = (state_q == ST_ISSUE);
        lm_lag_max = 16'd0;
        lm_lag_min = 16'd0;
        mult_a     = 16'd0;
        mult_b     = 16'd0;
        sub_a      = 16'd0;
        sub_b      = 16'd0;
        case (state_q)
            ST_ISSUE, ST_WAIT: begin
                lm_lag_max = band_max(band_q);
                lm_lag_min = band_min(band_q);
                mult_a     = lm_mult_a;
                mult_b     = lm_mult_b;
                sub_a      = lm_sub_a;
                sub_b      = lm_sub_b;
            end
            ST_CMP1: begin
                mult_a = cor_q[0];
                mult_b = THRESHPIT;
            end
            ST_CMP1S: begin
                sub_a = prod_q;
                sub_b = cor_q[1];
            end
            ST_CMP2: begin
                mult_a = max1_q;
                mult_b = THRESHPIT;
            end
            ST_CMP2S: begin
                sub_a = prod_q;
                sub_b = cor_q[2];
            end
            default: ;
        endcase
    end

    assign done = done_q;
    assign T_op = t_op_q;

endmodule
